// File: rtl/ifetch.sv
// RK16 instruction-fetch stage: single-outstanding imem reads, 2-entry {pc, inst}
// buffer toward decode, and redirect handling with discard of an in-flight read.
module ifetch #(
  parameter int            AW       = 16,
  parameter int            IW       = 32,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [IW-1:0] imem_rdata,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  output logic          id_valid,
  input  logic          id_ready,
  output logic [IW-1:0] id_inst,
  output logic [AW-1:0] id_pc
);

  // state   | meaning
  // S_IDLE  | no request outstanding (buffer full or just out of reset)
  // S_WAIT  | request to pc outstanding
  // S_DISCARD | stale request to hold_addr outstanding; its data will be dropped
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DISCARD} state_t;

  state_t        state, state_nx;
  logic [AW-1:0] pc, pc_nx;
  logic [AW-1:0] hold_addr, hold_nx;
  logic [1:0]    count, count_nx;
  logic          head;
  logic          tail;
  logic          push, pop;
  logic [AW-1:0] buf_pc   [2];
  logic [IW-1:0] buf_inst [2];

  assign pop      = (count != 2'd0) & id_ready;
  assign push     = (state == S_WAIT) & imem_ack & ~redirect_valid;
  assign count_nx = redirect_valid ? 2'd0 : count + {1'b0, push} - {1'b0, pop};
  assign tail     = head ^ count[0];

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    hold_nx  = hold_addr;
    case (state)
      S_IDLE: begin
        if (redirect_valid) pc_nx = redirect_pc;
        if (count_nx < 2'd2) state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (push) begin
          pc_nx    = pc + AW'(1);
          state_nx = (count_nx < 2'd2) ? S_WAIT : S_IDLE;
        end else if (imem_ack) begin
          pc_nx = redirect_pc;
        end else if (redirect_valid) begin
          // the old address must stay on the bus until memory acks it
          hold_nx  = pc;
          pc_nx    = redirect_pc;
          state_nx = S_DISCARD;
        end
      end
      S_DISCARD: begin
        if (redirect_valid) pc_nx = redirect_pc;
        if (imem_ack) state_nx = S_WAIT;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      hold_addr   <= RESET_PC;
      count       <= 2'd0;
      head        <= 1'b0;
      buf_pc[0]   <= '0;
      buf_pc[1]   <= '0;
      buf_inst[0] <= '0;
      buf_inst[1] <= '0;
    end else begin
      state     <= state_nx;
      pc        <= pc_nx;
      hold_addr <= hold_nx;
      count     <= count_nx;
      head      <= head ^ pop;
      if (push) begin
        buf_pc[tail]   <= pc;
        buf_inst[tail] <= imem_rdata;
      end
    end
  end

  assign imem_req  = (state != S_IDLE);
  assign imem_addr = (state == S_DISCARD) ? hold_addr : pc;
  assign id_valid  = (count != 2'd0);
  assign id_inst   = buf_inst[head];
  assign id_pc     = buf_pc[head];

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: memory model with programmable ack latency, and a queue-based
// reference of what decode should see, driven by directed scenarios plus random traffic.
module tb_ifetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_inst;
  logic [15:0] id_pc;

  ifetch #(.AW(16), .IW(32), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_inst(id_inst), .id_pc(id_pc)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference: pcs decode should see, next fetch pc, pending stale read
  logic [15:0] q[$];
  logic [15:0] seen[$];
  logic [15:0] fpc;
  logic [15:0] hold;
  logic        disc;
  int          lat;
  int          wcnt;
  int          acks;
  bit          rand_lat;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  // one clock cycle: compare outputs after the edge, then drive this cycle's inputs
  task automatic step(input logic rv, input logic [15:0] rpc, input logic rdy);
    logic ack;
    @(posedge clk);
    #1;
    check("req", {31'd0, imem_req}, {31'd0, q.size() < 2});
    if (imem_req) check("addr", {16'd0, imem_addr}, {16'd0, disc ? hold : fpc});
    check("valid", {31'd0, id_valid}, {31'd0, q.size() != 0});
    if (q.size() != 0) begin
      check("id_pc", {16'd0, id_pc}, {16'd0, q[0]});
      check("id_inst", id_inst, 32'hA000_0000 + {16'd0, q[0]});
    end
    ack = imem_req && (wcnt >= lat);
    wcnt = (imem_req && !ack) ? wcnt + 1 : 0;
    imem_ack = ack;
    imem_rdata = ack ? 32'hA000_0000 + {16'd0, imem_addr} : $urandom;
    redirect_valid = rv;
    redirect_pc = rpc;
    id_ready = rdy;
    if (ack) acks++;
    if (ack && rand_lat) lat = $urandom_range(0, 3);
    if (q.size() != 0 && rdy) seen.push_back(q.pop_front());
    if (disc) begin
      if (ack) disc = 1'b0;
    end else if (ack && !rv) begin
      q.push_back(fpc);
      fpc = fpc + 16'd1;
    end else if (imem_req && !ack && rv) begin
      disc = 1'b1;
      hold = fpc;
    end
    if (rv) begin
      q.delete();
      fpc = rpc;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    imem_ack = 1'b0;
    redirect_valid = 1'b0;
    id_ready = 1'b0;
    q.delete();
    seen.delete();
    fpc = 16'h0000;
    disc = 1'b0;
    wcnt = 0;
    acks = 0;
    #1;
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, id_valid}, 32'd0);
    check("rst_addr", {16'd0, imem_addr}, 32'd0);
    check("rst_inst", id_inst, 32'd0);
    check("rst_pc", {16'd0, id_pc}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_seen(input string tag, input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] c, input logic [15:0] d, input int n);
    logic [15:0] e[4];
    e[0] = a; e[1] = b; e[2] = c; e[3] = d;
    check({tag, "_n"}, 32'(seen.size() >= n), 32'd1);
    for (int i = 0; i < n && i < seen.size(); i++)
      check(tag, {16'd0, seen[i]}, {16'd0, e[i]});
  endtask

  initial begin
    int k;
    rand_lat = 0;
    lat = 0;

    // zero-wait memory, decode always ready
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b0, 16'h0, 1'b1);
    check("t1_pops", seen.size(), 32'd9);
    check_seen("t1_seq", 16'd0, 16'd1, 16'd2, 16'd3, 4);

    // decode stalled: buffer fills after two acks, then drains in order
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b0, 16'h0, 1'b0);
    check("t2_acks", acks, 32'd2);
    for (int i = 0; i < 4; i++) step(1'b0, 16'h0, 1'b1);
    check_seen("t2_seq", 16'd0, 16'd1, 16'd2, 16'd3, 3);

    // slow memory, redirect while the read of address 5 is outstanding
    do_reset();
    lat = 3;
    k = 0;
    while (!(imem_req && imem_addr == 16'd5) && k < 100) begin
      step(1'b0, 16'h0, 1'b1);
      k++;
    end
    check("t3_reach5", 32'(k < 100), 32'd1);
    step(1'b0, 16'h0, 1'b1);
    seen.delete();
    step(1'b1, 16'h0100, 1'b1);
    for (int i = 0; i < 14; i++) step(1'b0, 16'h0, 1'b1);
    check_seen("t3_seq", 16'h0100, 16'h0101, 16'h0, 16'h0, 2);

    // wrap at the top of the address space
    lat = 0;
    step(1'b1, 16'hFFFE, 1'b1);
    seen.delete();
    for (int i = 0; i < 6; i++) step(1'b0, 16'h0, 1'b1);
    check_seen("t4_seq", 16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001, 4);

    // redirect coinciding with an ack right after draining a full buffer
    for (int i = 0; i < 5; i++) step(1'b0, 16'h0, 1'b0);
    step(1'b0, 16'h0, 1'b1);
    k = 0;
    while (!imem_req && k < 20) begin
      step(1'b0, 16'h0, 1'b1);
      k++;
    end
    step(1'b1, 16'h0200, 1'b1);
    check("t5_ack", {31'd0, imem_ack}, 32'd1);
    seen.delete();
    for (int i = 0; i < 5; i++) step(1'b0, 16'h0, 1'b1);
    check_seen("t5_seq", 16'h0200, 16'h0201, 16'h0, 16'h0, 2);

    // asynchronous reset between edges while a read is outstanding
    lat = 3;
    for (int i = 0; i < 6; i++) step(1'b0, 16'h0, 1'b1);
    check("t6_pre_req", {31'd0, imem_req}, 32'd1);
    #3;
    do_reset();
    lat = 0;
    for (int i = 0; i < 5; i++) step(1'b0, 16'h0, 1'b1);
    check_seen("t6_seq", 16'd0, 16'd1, 16'd2, 16'd3, 4);

    // random traffic: varying latency, backpressure and redirects
    rand_lat = 1;
    for (int i = 0; i < 1500; i++) begin
      logic        rv;
      logic [15:0] rpc;
      rv  = ($urandom_range(0, 99) < 6);
      rpc = ($urandom_range(0, 3) == 0) ? 16'hFFFC + 16'($urandom_range(0, 3)) : 16'($urandom);
      step(rv, rpc, $urandom_range(0, 99) < 70);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
